// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between a CPU load/store unit (master)
// and the memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store, waits
// LATENCY cycles, commits to a byte-lane word array and returns a response.
module dmem_responder #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_load_q, rsp_load_d;

  logic [31:0] word_idx;
  logic [AW-1:0] idx;
  logic        err_c;
  logic        commit_c;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] rd_word;

  assign word_idx = {2'b00, addr_q[31:2]};
  assign idx      = addr_q[AW+1:2];
  assign err_c    = (addr_q[1:0] != 2'b00) || (word_idx >= 32'(DEPTH));
  assign commit_c = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign mem_we   = commit_c && write_q && !err_c;
  assign mem_re   = commit_c && !write_q && !err_c;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_load_d  = rsp_load_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          cnt_d   = 4'(LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Counter at zero means this edge is the commit edge.
        if (cnt_q == 4'd0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_c;
          rsp_load_d  = !write_q && !err_c;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_load_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_load_q  <= rsp_load_d;
    end
  end

  // One byte-wide array per lane so each lane's enable maps onto its own RAM.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_rd_q;

    always_ff @(posedge clk) begin
      if (mem_we && be_q[gi]) begin
        lane_mem[idx] <= wdata_q[8*gi +: 8];
      end
      if (mem_re) begin
        lane_rd_q <= lane_mem[idx];
      end
    end

    assign rd_word[8*gi +: 8] = lane_rd_q;
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_load_q ? rd_word : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=2 instance for the main
// sequence and one LATENCY=0 instance for back-to-back traffic.
module tb_dmem_responder;

  localparam int DEPTH_A = 512;
  localparam int LAT_A   = 2;
  localparam int DEPTH_B = 16;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.DEPTH(DEPTH_A), .LATENCY(LAT_A)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  dmem_responder #(.DEPTH(DEPTH_B), .LATENCY(0)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Issue one request on instance A; hold rsp_ready low for `hold` cycles of RESP.
  task automatic req_a(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int hold,
                       output logic [31:0] rd, output logic er, output int lat);
    int n;
    bus_a.req_write = w;
    bus_a.req_addr  = a;
    bus_a.req_wdata = wd;
    bus_a.req_be    = be;
    bus_a.rsp_ready = (hold == 0);
    bus_a.req_valid = 1'b1;
    n = 0;
    while (!bus_a.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    bus_a.req_addr  = 32'hFFFF_FFFF;
    bus_a.req_wdata = ~wd;
    bus_a.req_be    = ~be;
    bus_a.req_write = ~w;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus_a.rsp_valid && lat < 40);
    if (!bus_a.rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    rd = bus_a.rsp_rdata;
    er = bus_a.rsp_err;
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, bus_a.rsp_valid}, 32'd1);
      check("hold_rdata", bus_a.rsp_rdata, rd);
      check("hold_err", {31'd0, bus_a.rsp_err}, {31'd0, er});
      check("hold_req_ready", {31'd0, bus_a.req_ready}, 32'd0);
    end
    bus_a.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_valid", {31'd0, bus_a.rsp_valid}, 32'd0);
    check("post_hs_req_ready", {31'd0, bus_a.req_ready}, 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  // Back-to-back table for instance B.
  logic        tw  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] ta  [4] = '{32'h4, 32'h8, 32'h4, 32'h8};
  logic [31:0] twd [4] = '{32'h0A0B0C0D, 32'h01020304, 32'h0, 32'h0};
  logic [31:0] texp[4] = '{32'h0, 32'h0, 32'h0A0B0C0D, 32'h01020304};
  int          acc_cyc[4];
  int          rsp_cyc[4];
  logic [31:0] got_d[4];
  logic        got_e[4];

  initial begin
    int k;
    int r;
    int vmax;
    logic fire;
    total = 0;
    bad   = 0;
    bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_addr = 32'd0;
    bus_a.req_wdata = 32'd0; bus_a.req_be = 4'd0; bus_a.rsp_ready = 1'b1;
    bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_addr = 32'd0;
    bus_b.req_wdata = 32'd0; bus_b.req_be = 4'd0; bus_b.rsp_ready = 1'b1;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, bus_a.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, bus_a.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", bus_a.rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, bus_a.rsp_err}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Full-word store then load.
    req_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    check("sw10_lat", 32'(lat), 32'(LAT_A + 1));
    check("sw10_rdata", rd, 32'd0);
    check("sw10_err", {31'd0, er}, 32'd0);
    req_a(1'b0, 32'h10, 32'd0, 4'h0, 0, rd, er, lat);
    check("lw10_lat", 32'(lat), 32'(LAT_A + 1));
    check("lw10_rdata", rd, 32'hDEADBEEF);
    check("lw10_err", {31'd0, er}, 32'd0);

    // Partial-lane store.
    req_a(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat);
    req_a(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat);
    req_a(1'b0, 32'h20, 32'd0, 4'h0, 0, rd, er, lat);
    check("lw20_lanes", rd, 32'h11BB33DD);

    // Empty byte enable is a no-op store without error.
    req_a(1'b1, 32'h10, 32'h00000000, 4'h0, 0, rd, er, lat);
    check("sw_be0_err", {31'd0, er}, 32'd0);
    req_a(1'b0, 32'h10, 32'd0, 4'h0, 0, rd, er, lat);
    check("lw10_after_be0", rd, 32'hDEADBEEF);

    // Error cases; word 4*DEPTH would alias word 0 if the range check were missing.
    req_a(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, rd, er, lat);
    req_a(1'b0, 32'h13, 32'd0, 4'hF, 0, rd, er, lat);
    check("lw13_err", {31'd0, er}, 32'd1);
    check("lw13_rdata", rd, 32'd0);
    check("lw13_lat", 32'(lat), 32'(LAT_A + 1));
    req_a(1'b1, 32'(4 * DEPTH_A), 32'h55555555, 4'hF, 0, rd, er, lat);
    check("sw_oor_err", {31'd0, er}, 32'd1);
    check("sw_oor_rdata", rd, 32'd0);
    req_a(1'b0, 32'h0, 32'd0, 4'h0, 0, rd, er, lat);
    check("lw0_unchanged", rd, 32'hCAFEF00D);
    check("lw0_err", {31'd0, er}, 32'd0);

    // Back-pressure on the response channel.
    req_a(1'b0, 32'h20, 32'd0, 4'h0, 5, rd, er, lat);
    check("bp_rdata", rd, 32'h11BB33DD);

    // Reset during WAIT aborts the store.
    req_a(1'b1, 32'h40, 32'h12345678, 4'hF, 0, rd, er, lat);
    bus_a.req_write = 1'b1;
    bus_a.req_addr  = 32'h40;
    bus_a.req_wdata = 32'h5;
    bus_a.req_be    = 4'hF;
    bus_a.req_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    check("acc_req_ready", {31'd0, bus_a.req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("abort_req_ready", {31'd0, bus_a.req_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    vmax = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus_a.rsp_valid) vmax = 1;
      @(posedge clk); #1;
    end
    check("abort_no_rsp", 32'(vmax), 32'd0);
    req_a(1'b0, 32'h40, 32'd0, 4'h0, 0, rd, er, lat);
    check("lw40_old", rd, 32'h12345678);

    // Back-to-back traffic on the zero-latency instance.
    k = 0;
    r = 0;
    bus_b.req_write = tw[0];
    bus_b.req_addr  = ta[0];
    bus_b.req_wdata = twd[0];
    bus_b.req_be    = 4'hF;
    bus_b.req_valid = 1'b1;
    for (int n = 0; n < 60 && r < 4; n++) begin
      fire = bus_b.req_valid && bus_b.req_ready;
      if (bus_b.rsp_valid) begin
        got_d[r]   = bus_b.rsp_rdata;
        got_e[r]   = bus_b.rsp_err;
        rsp_cyc[r] = cyc;
        r++;
      end
      @(posedge clk); #1;
      if (fire) begin
        acc_cyc[k] = cyc;
        k++;
        if (k < 4) begin
          bus_b.req_write = tw[k];
          bus_b.req_addr  = ta[k];
          bus_b.req_wdata = twd[k];
        end else begin
          bus_b.req_valid = 1'b0;
        end
      end
    end
    check("b2b_rsp_count", 32'(r), 32'd4);
    for (int i = 0; i < r; i++) begin
      check("b2b_rdata", got_d[i], texp[i]);
      check("b2b_err", {31'd0, got_e[i]}, 32'd0);
      check("b2b_lat", 32'(rsp_cyc[i] - acc_cyc[i]), 32'd1);
      if (i > 0) check("b2b_accept_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
